// File: rtl/cv32e40x_div.sv
// Iterative RV32M divider (DIV/DIVU/REM/REMU) with one restoring step per cycle.
// Borrows the ALU CLZ unit and shifter to left-align the divisor before iterating.
module cv32e40x_div (
  input  logic        clk,
  input  logic        rst,
  input  logic        kill_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [1:0]  op_i,
  input  logic [31:0] op_a_i,
  input  logic [31:0] op_b_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] result_o,
  output logic        alu_clz_en_o,
  output logic [31:0] alu_clz_data_o,
  input  logic [5:0]  alu_clz_result_i,
  output logic        alu_shift_en_o,
  output logic [5:0]  alu_shift_amt_o,
  output logic [31:0] alu_op_a_o,
  input  logic [31:0] alu_op_a_shifted_i
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLZ   = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_ITER  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] dvsr_q, dvsr_d;
  logic [31:0] quot_q, quot_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [1:0]  op_q, op_d;
  logic        sign_a_q, sign_a_d;
  logic        sign_q_q, sign_q_d;
  logic        b_zero_q, b_zero_d;

  logic        signed_op;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic        rem_ge;
  logic [31:0] div_res;
  logic [31:0] rem_res;

  always_comb begin
    signed_op = ~op_i[0];
    a_neg     = signed_op & op_a_i[31];
    b_neg     = signed_op & op_b_i[31];
    abs_a     = a_neg ? (32'd0 - op_a_i) : op_a_i;
    abs_b     = b_neg ? (32'd0 - op_b_i) : op_b_i;
    rem_ge    = (rem_q >= dvsr_q);
  end

  // Until SHIFT overwrites it, dvsr holds |b| so CLZ and SHIFT can present it to the ALU.
  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    dvsr_d   = dvsr_q;
    quot_d   = quot_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    sign_a_d = sign_a_q;
    sign_q_d = sign_q_q;
    b_zero_d = b_zero_q;

    if (kill_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (valid_i) begin
            op_d     = op_i;
            sign_a_d = a_neg;
            sign_q_d = a_neg ^ b_neg;
            b_zero_d = (op_b_i == 32'd0);
            quot_d   = '0;
            cnt_d    = '0;
            dvsr_d   = abs_b;
            if (op_b_i == 32'd0) begin
              rem_d   = op_a_i;
              state_d = S_DONE;
            end else begin
              rem_d   = abs_a;
              state_d = S_CLZ;
            end
          end
        end
        S_CLZ: begin
          // A count of 32 only occurs for a zero operand, which never reaches CLZ.
          cnt_d   = alu_clz_result_i[5] ? 5'd31 : alu_clz_result_i[4:0];
          state_d = S_SHIFT;
        end
        S_SHIFT: begin
          dvsr_d  = alu_op_a_shifted_i;
          state_d = S_ITER;
        end
        S_ITER: begin
          if (rem_ge) begin
            rem_d = rem_q - dvsr_q;
          end
          quot_d = {quot_q[30:0], rem_ge};
          dvsr_d = {1'b0, dvsr_q[31:1]};
          if (cnt_q == 5'd0) begin
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q - 5'd1;
          end
        end
        S_DONE: begin
          if (ready_i) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      rem_q    <= '0;
      dvsr_q   <= '0;
      quot_q   <= '0;
      cnt_q    <= '0;
      op_q     <= '0;
      sign_a_q <= 1'b0;
      sign_q_q <= 1'b0;
      b_zero_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      dvsr_q   <= dvsr_d;
      quot_q   <= quot_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      sign_a_q <= sign_a_d;
      sign_q_q <= sign_q_d;
      b_zero_q <= b_zero_d;
    end
  end

  always_comb begin
    if (b_zero_q) begin
      div_res = '1;
      rem_res = rem_q;
    end else begin
      div_res = (!op_q[0] && sign_q_q) ? (32'd0 - quot_q) : quot_q;
      rem_res = sign_a_q ? (32'd0 - rem_q) : rem_q;
    end
  end

  always_comb begin
    ready_o         = (state_q == S_IDLE);
    valid_o         = (state_q == S_DONE);
    result_o        = (state_q == S_DONE) ? (op_q[1] ? rem_res : div_res) : '0;
    alu_clz_en_o    = (state_q == S_CLZ);
    alu_clz_data_o  = (state_q == S_CLZ) ? dvsr_q : '0;
    alu_shift_en_o  = (state_q == S_SHIFT);
    alu_shift_amt_o = (state_q == S_SHIFT) ? {1'b0, cnt_q} : '0;
    alu_op_a_o      = (state_q == S_SHIFT) ? dvsr_q : '0;
  end

endmodule

// File: tb/tb_cv32e40x_div.sv
// Randomized and directed checks of cv32e40x_div against an arithmetic reference model.
module tb_cv32e40x_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        kill_i;
  logic        valid_i;
  logic        ready_o;
  logic [1:0]  op_i;
  logic [31:0] op_a_i;
  logic [31:0] op_b_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] result_o;
  logic        alu_clz_en_o;
  logic [31:0] alu_clz_data_o;
  logic [5:0]  alu_clz_result_i;
  logic        alu_shift_en_o;
  logic [5:0]  alu_shift_amt_o;
  logic [31:0] alu_op_a_o;
  logic [31:0] alu_op_a_shifted_i;

  int n_checks = 0;
  int n_pass   = 0;

  cv32e40x_div dut (
    .clk                (clk),
    .rst                (rst),
    .kill_i             (kill_i),
    .valid_i            (valid_i),
    .ready_o            (ready_o),
    .op_i               (op_i),
    .op_a_i             (op_a_i),
    .op_b_i             (op_b_i),
    .valid_o            (valid_o),
    .ready_i            (ready_i),
    .result_o           (result_o),
    .alu_clz_en_o       (alu_clz_en_o),
    .alu_clz_data_o     (alu_clz_data_o),
    .alu_clz_result_i   (alu_clz_result_i),
    .alu_shift_en_o     (alu_shift_en_o),
    .alu_shift_amt_o    (alu_shift_amt_o),
    .alu_op_a_o         (alu_op_a_o),
    .alu_op_a_shifted_i (alu_op_a_shifted_i)
  );

  always #5 clk = ~clk;

  function automatic int clz32(input logic [31:0] v);
    for (int i = 31; i >= 0; i--) begin
      if (v[i]) return 31 - i;
    end
    return 32;
  endfunction

  // Stand-in for the ALU count-leading-zeros unit and shifter.
  always_comb begin
    alu_clz_result_i   = 6'(clz32(alu_clz_data_o));
    alu_op_a_shifted_i = alu_op_a_o << alu_shift_amt_o;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int sa;
    int sb;
    sa = a;
    sb = b;
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    case (op)
      2'd0: return (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h8000_0000 : 32'(sa / sb);
      2'd1: return a / b;
      2'd2: return (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'd0 : 32'(sa % sb);
      default: return a % b;
    endcase
  endfunction

  function automatic logic alu_quiet();
    return !alu_clz_en_o && alu_clz_data_o == 32'd0 && !alu_shift_en_o &&
           alu_shift_amt_o == 6'd0 && alu_op_a_o == 32'd0;
  endfunction

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input int hold);
    logic [31:0] exp;
    logic [31:0] absb;
    logic [31:0] first;
    int          lat;
    int          cyc;
    int          clzb;
    logic        alu_ok;
    logic        stable;
    exp  = ref_res(op, a, b);
    absb = (!op[0] && b[31]) ? (32'd0 - b) : b;
    clzb = clz32(absb);
    lat  = (b == 32'd0) ? 1 : clzb + 4;
    op_i = op; op_a_i = a; op_b_i = b; valid_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid_i = 1'b0;
    op_a_i  = $urandom;
    op_b_i  = $urandom;
    cyc     = 1;
    alu_ok  = 1'b1;
    while (!valid_o && cyc < 64) begin
      if (b != 32'd0 && cyc == 1) begin
        if (!(alu_clz_en_o && alu_clz_data_o == absb && !alu_shift_en_o &&
              alu_shift_amt_o == 6'd0 && alu_op_a_o == 32'd0)) alu_ok = 1'b0;
      end else if (b != 32'd0 && cyc == 2) begin
        if (!(alu_shift_en_o && alu_shift_amt_o == 6'(clzb) && alu_op_a_o == absb &&
              !alu_clz_en_o && alu_clz_data_o == 32'd0)) alu_ok = 1'b0;
      end else if (!alu_quiet()) begin
        alu_ok = 1'b0;
      end
      if (ready_o) alu_ok = 1'b0;
      @(negedge clk);
      cyc++;
    end
    if (!alu_quiet()) alu_ok = 1'b0;
    check($sformatf("latency op%0d %h/%h", op, a, b), 32'(cyc), 32'(lat));
    check($sformatf("result op%0d %h/%h", op, a, b), result_o, exp);
    check("alu_sequence", 32'(alu_ok), 32'd1);
    if (!valid_o) begin
      kill_i = 1'b1;
      @(posedge clk);
      @(negedge clk);
      kill_i = 1'b0;
      return;
    end
    first  = result_o;
    stable = 1'b1;
    repeat (hold) begin
      @(negedge clk);
      if (!valid_o || ready_o || result_o !== first) stable = 1'b0;
    end
    if (hold > 0) check("backpressure_hold", 32'(stable), 32'd1);
    ready_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ready_i = 1'b0;
    check("back_to_idle", 32'({ready_o, valid_o}), 32'd2);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_rdy_vld"}, 32'({ready_o, valid_o}), 32'd2);
    check({tag, "_result"}, result_o, 32'd0);
    check({tag, "_alu"}, 32'(alu_quiet()), 32'd1);
  endtask

  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    op_i = op; op_a_i = a; op_b_i = b; valid_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid_i = 1'b0;
  endtask

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    rst = 1'b1; kill_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
    op_i = '0; op_a_i = '0; op_b_i = '0;
    repeat (3) @(negedge clk);
    check_idle("reset");
    rst = 1'b0;
    @(negedge clk);

    run_op(2'd1, 32'd100, 32'd7, 0);
    run_op(2'd3, 32'd100, 32'd7, 0);
    run_op(2'd0, 32'hFFFF_FFF9, 32'd2, 0);
    run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 0);
    run_op(2'd1, 32'hFFFF_FFFF, 32'h8000_0000, 0);
    run_op(2'd1, 32'd5, 32'd0, 0);
    run_op(2'd2, 32'hFFFF_FFFB, 32'd0, 0);
    run_op(2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(2'd1, 32'd100, 32'd7, 5);
    run_op(2'd1, 32'd9, 32'd3, 0);

    // kill during ITER (cycle 4), with a stray valid_i that must be ignored
    start_op(2'd1, 32'd1000, 32'd3);
    repeat (3) @(negedge clk);
    kill_i = 1'b1; valid_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    kill_i = 1'b0; valid_i = 1'b0;
    check_idle("kill_iter");
    @(negedge clk);
    check_idle("kill_iter_settled");
    run_op(2'd1, 32'd8, 32'd2, 0);

    // reset during SHIFT (cycle 2)
    start_op(2'd1, 32'd1000, 32'd3);
    @(negedge clk);
    check("in_shift", 32'(alu_shift_en_o), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_idle("rst_shift");
    run_op(2'd1, 32'd8, 32'd2, 0);

    // kill coincident with ready_i in DONE
    start_op(2'd1, 32'd5, 32'd0);
    check("dz_done", 32'(valid_o), 32'd1);
    kill_i = 1'b1; ready_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    kill_i = 1'b0; ready_i = 1'b0;
    check_idle("kill_done");

    // kill in IDLE blocks the accept
    op_i = 2'd1; op_a_i = 32'd7; op_b_i = 32'd0; valid_i = 1'b1; kill_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid_i = 1'b0; kill_i = 1'b0;
    check_idle("kill_idle");

    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = 32'hFFFF_FFFF;
        3:       rb = 32'h8000_0000 | $urandom;
        default: rb = $urandom >> $urandom_range(0, 31);
      endcase
      run_op(rop, ra, rb, $urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
